// File: rtl/button_events.sv
// Gesture classifier for one debounced push-button: emits registered one-cycle
// pulses for short press, double click, long press and auto-repeat while held.
module button_events #(
    parameter int unsigned p_long_cycles   = 25_000_000,
    parameter int unsigned p_double_gap    = 7_500_000,
    parameter int unsigned p_repeat_cycles = 5_000_000,
    parameter int unsigned p_cnt_width     = 32
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_short,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_held,
    output logic o_busy
);

    localparam logic [63:0] CNT_MAX = (64'd1 << p_cnt_width) - 64'd1;

    if (p_long_cycles < 2) begin : g_chk_long_min
        $error("button_events: p_long_cycles must be >= 2");
    end
    if (p_double_gap < 2) begin : g_chk_gap_min
        $error("button_events: p_double_gap must be >= 2");
    end
    if (p_cnt_width < 1) begin : g_chk_width_min
        $error("button_events: p_cnt_width must be >= 1");
    end
    if ((64'(p_long_cycles) - 64'd1 > CNT_MAX) ||
        (64'(p_double_gap) - 64'd1 > CNT_MAX) ||
        ((p_repeat_cycles != 0) && (64'(p_repeat_cycles) - 64'd1 > CNT_MAX))) begin : g_chk_range
        $error("button_events: p_cnt_width too small for the configured cycle counts");
    end

    localparam logic [p_cnt_width-1:0] CNT_ONE   = p_cnt_width'(32'd1);
    localparam logic [p_cnt_width-1:0] LONG_LAST = p_cnt_width'(p_long_cycles - 32'd1);
    localparam logic [p_cnt_width-1:0] GAP_LAST  = p_cnt_width'(p_double_gap - 32'd1);
    localparam logic [p_cnt_width-1:0] REP_LAST  =
        p_cnt_width'((p_repeat_cycles == 32'd0) ? 32'd0 : p_repeat_cycles - 32'd1);
    localparam bit REPEAT_EN = (p_repeat_cycles != 32'd0);

    typedef enum logic [2:0] {
        S_WAIT_REL,
        S_IDLE,
        S_PRESS1,
        S_GAP,
        S_PRESS2,
        S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [p_cnt_width-1:0] cnt_q, cnt_d;
    logic                   short_q, short_d;
    logic                   dbl_q, dbl_d;
    logic                   long_q, long_d;
    logic                   repeat_q, repeat_d;
    logic                   held_q, held_d;
    logic                   busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        short_d  = 1'b0;
        dbl_d    = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        unique case (state_q)
            S_WAIT_REL: begin
                if (!i_btn) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (i_btn) state_d = S_PRESS1;
            end
            S_PRESS1: begin
                if (i_btn) begin
                    if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // A press on the expiry edge wins over the short-press verdict.
                if (i_btn) begin
                    state_d = S_PRESS2;
                end else if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PRESS2: begin
                if (!i_btn) begin
                    dbl_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (i_btn) begin
                    if (REPEAT_EN) begin
                        if (cnt_q == REP_LAST) begin
                            repeat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_WAIT_REL;
            end
        endcase

        held_d = (state_d == S_HOLD);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_WAIT_REL;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            dbl_q    <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            dbl_q    <= dbl_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
            busy_q   <= busy_d;
        end
    end

    assign o_short  = short_q;
    assign o_double = dbl_q;
    assign o_long   = long_q;
    assign o_repeat = repeat_q;
    assign o_held   = held_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: two instances (repeat enabled / disabled) driven by the
// same button, checked every cycle against a timestamp-based gesture model.
module tb_button_events;

    localparam int unsigned LC = 8;
    localparam int unsigned DG = 4;
    localparam int unsigned RC = 3;
    localparam int unsigned CW = 8;

    localparam int M_WAIT = 0;
    localparam int M_IDLE = 1;
    localparam int M_P1   = 2;
    localparam int M_GAP  = 3;
    localparam int M_P2   = 4;
    localparam int M_HOLD = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [1:0] sh, db, lg, rp, hd, bz;

    button_events #(
        .p_long_cycles  (LC),
        .p_double_gap   (DG),
        .p_repeat_cycles(RC),
        .p_cnt_width    (CW)
    ) u_dut_rep (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn),
        .o_short (sh[0]),
        .o_double(db[0]),
        .o_long  (lg[0]),
        .o_repeat(rp[0]),
        .o_held  (hd[0]),
        .o_busy  (bz[0])
    );

    button_events #(
        .p_long_cycles  (LC),
        .p_double_gap   (DG),
        .p_repeat_cycles(0),
        .p_cnt_width    (CW)
    ) u_dut_norep (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn),
        .o_short (sh[1]),
        .o_double(db[1]),
        .o_long  (lg[1]),
        .o_repeat(rp[1]),
        .o_held  (hd[1]),
        .o_busy  (bz[1])
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Gesture model: edge timestamps of press start, release and long-press.
    int t = 0;
    int ph[2];
    int t_press[2];
    int t_rel[2];
    int t_long[2];
    int rcyc[2] = '{int'(RC), 0};
    bit e_sh[2], e_db[2], e_lg[2], e_rp[2], e_hd[2], e_bz[2];

    int n_sh[2], n_db[2], n_lg[2], n_rp[2];
    int t_start;
    int t_long_seen;
    int q_rep[$];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = M_WAIT;
            e_sh[k] = 0; e_db[k] = 0; e_lg[k] = 0; e_rp[k] = 0;
            e_hd[k] = 0; e_bz[k] = 0;
        end
    endtask

    task automatic model_step(input bit b);
        t++;
        for (int k = 0; k < 2; k++) begin
            e_sh[k] = 0; e_db[k] = 0; e_lg[k] = 0; e_rp[k] = 0;
            case (ph[k])
                M_WAIT: if (!b) ph[k] = M_IDLE;
                M_IDLE: if (b) begin ph[k] = M_P1; t_press[k] = t; end
                M_P1: begin
                    if (!b) begin
                        ph[k] = M_GAP; t_rel[k] = t;
                    end else if (t - t_press[k] == int'(LC)) begin
                        e_lg[k] = 1; ph[k] = M_HOLD; t_long[k] = t;
                    end
                end
                M_GAP: begin
                    if (b) ph[k] = M_P2;
                    else if (t - t_rel[k] == int'(DG)) begin e_sh[k] = 1; ph[k] = M_IDLE; end
                end
                M_P2: if (!b) begin e_db[k] = 1; ph[k] = M_IDLE; end
                M_HOLD: begin
                    if (!b) ph[k] = M_IDLE;
                    else if (rcyc[k] != 0 && (t - t_long[k]) % rcyc[k] == 0) e_rp[k] = 1;
                end
                default: ph[k] = M_WAIT;
            endcase
            e_hd[k] = (ph[k] == M_HOLD);
            e_bz[k] = (ph[k] != M_IDLE);
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("short[%0d]", k),  sh[k], e_sh[k]);
            chk($sformatf("double[%0d]", k), db[k], e_db[k]);
            chk($sformatf("long[%0d]", k),   lg[k], e_lg[k]);
            chk($sformatf("repeat[%0d]", k), rp[k], e_rp[k]);
            chk($sformatf("held[%0d]", k),   hd[k], e_hd[k]);
            chk($sformatf("busy[%0d]", k),   bz[k], e_bz[k]);
            chk($sformatf("onehot[%0d]", k),
                logic'($onehot0({sh[k], db[k], lg[k], rp[k]})), 1'b1);
            n_sh[k] += int'(sh[k]);
            n_db[k] += int'(db[k]);
            n_lg[k] += int'(lg[k]);
            n_rp[k] += int'(rp[k]);
        end
        if (lg[0] === 1'b1 && t_long_seen < 0) t_long_seen = t;
        if (rp[0] === 1'b1) q_rep.push_back(t);
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            n_sh[k] = 0; n_db[k] = 0; n_lg[k] = 0; n_rp[k] = 0;
        end
        t_long_seen = -1;
        q_rep.delete();
    endtask

    task automatic cycle(input bit b);
        btn = b;
        @(posedge clk);
        if (rst_n) model_step(b);
        #1;
        check_all();
    endtask

    task automatic run(input bit b, input int n);
        for (int i = 0; i < n; i++) cycle(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int rep_exp[4];
        rep_exp = '{11, 14, 17, 20};
        rst_n = 1'b0;
        btn   = 1'b0;
        clear_counts();
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        run(0, 3);

        // Short press
        clear_counts();
        run(1, 3); run(0, 8);
        chk_int("short_press.n_short", n_sh[0], 1);
        chk_int("short_press.n_other", n_db[0] + n_lg[0] + n_rp[0], 0);

        // Double click
        clear_counts();
        run(1, 2); run(0, 2); run(1, 2); run(0, 8);
        chk_int("double.n_double", n_db[0], 1);
        chk_int("double.n_short", n_sh[0], 0);

        // Gap expires, then a fresh press
        clear_counts();
        run(1, 2); run(0, 5); run(1, 2); run(0, 8);
        chk_int("gap_expire.n_short", n_sh[0], 2);
        chk_int("gap_expire.n_double", n_db[0], 0);

        // Press on the expiry edge takes priority
        clear_counts();
        run(1, 2); run(0, 4); run(1, 2); run(0, 8);
        chk_int("gap_edge.n_double", n_db[0], 1);
        chk_int("gap_edge.n_short", n_sh[0], 0);

        clear_counts();
        run(1, 2); run(0, 3); run(1, 2); run(0, 8);
        chk_int("gap_short.n_double", n_db[0], 1);

        // Long hold with and without repeat
        clear_counts();
        t_start = t + 1;
        run(1, 21); run(0, 4);
        chk_int("long.edge", t_long_seen - t_start, int'(LC));
        chk_int("long.n_long_rep", n_lg[0], 1);
        chk_int("long.n_long_norep", n_lg[1], 1);
        chk_int("long.n_repeat_norep", n_rp[1], 0);
        chk_int("long.n_repeat", q_rep.size(), 4);
        for (int i = 0; i < 4 && i < q_rep.size(); i++)
            chk_int($sformatf("long.repeat_edge%0d", i), q_rep[i] - t_start, rep_exp[i]);

        // Reset while held
        clear_counts();
        run(1, 3);
        do_reset();
        run(1, 20); run(0, 2);
        chk_int("rst_held.n_events", n_sh[0] + n_db[0] + n_lg[0] + n_rp[0], 0);
        run(1, 3); run(0, 8);
        chk_int("rst_held.n_short_after", n_sh[0], 1);

        // Random gestures
        for (int g = 0; g < 60; g++) begin
            run(1, int'($urandom_range(1, 22)));
            if (g == 30) do_reset();
            run(0, int'($urandom_range(1, 7)));
        end
        run(0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
